lifo_stack_core: RTL and testbench

//  Storage and pointer engine of the LIFO. Accepts push (wr) and pop (rd) requests.

---
 rtl/lifo_pkg.sv | 24 ++
 rtl/lifo_ram.sv | 34 +++
 rtl/lifo_stack_core.sv | 109 ++++++++++
 tb/tb_lifo_stack_core.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
// rtl/lifo_pkg.sv - shared LIFO defaults, state encoding and state decode helper
package lifo_pkg;

    localparam int LIFO_DATA_WIDTH    = 16;
    localparam int LIFO_POINTER_WIDTH = 4;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PART  = 2'd1,
        S_FULL  = 2'd2
    } lifo_state_t;

    // State is a pure function of the occupancy it describes
    function automatic lifo_state_t lifo_state_for(input logic at_zero, input logic at_full);
        if (at_zero) begin
            return S_EMPTY;
        end else if (at_full) begin
            return S_FULL;
        end else begin
            return S_PART;
        end
    endfunction

endpackage

// File: rtl/lifo_ram.sv
// rtl/lifo_ram.sv - register-array storage, one sync write port, one registered read port
module lifo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port; same-address write in this cycle returns the old word
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lifo_stack_core.sv
// rtl/lifo_stack_core.sv - LIFO pointer engine, FSM and error flags (LIFO_STICKY_ERR_EN makes ov/ud sticky)
module lifo_stack_core
    import lifo_pkg::*;
#(
    parameter int DATA_WIDTH    = LIFO_DATA_WIDTH,
    parameter int POINTER_WIDTH = LIFO_POINTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid,
    output logic                     lifo_empty,
    output logic                     lifo_full,
    output logic [POINTER_WIDTH:0]   pointer,
    output logic                     lifo_ov,
    output logic                     lifo_ud
);

    localparam int                 DEPTH      = 1 << POINTER_WIDTH;
    localparam logic [POINTER_WIDTH:0] FULL_COUNT = (POINTER_WIDTH+1)'(DEPTH);
    localparam logic [POINTER_WIDTH:0] ONE        = (POINTER_WIDTH+1)'(1);

    lifo_state_t state;
    lifo_state_t state_next;

    logic                     is_empty;
    logic                     is_full;
    logic                     push_only;
    logic                     pop_only;
    logic                     swap;
    logic                     push_on_empty;
    logic                     do_write;
    logic                     do_read;
    logic                     ov_now;
    logic                     ud_now;
    logic [POINTER_WIDTH:0]   ptr_minus1;
    logic [POINTER_WIDTH:0]   ptr_next;
    logic [POINTER_WIDTH-1:0] waddr;
    logic [POINTER_WIDTH-1:0] raddr;

    assign is_empty = (state == S_EMPTY);
    assign is_full  = (state == S_FULL);

    // Request decode: classify the cycle and pick RAM addresses and the next pointer
    always_comb begin
        push_only     = wr & ~rd & ~is_full;
        pop_only      = rd & ~wr & ~is_empty;
        swap          = wr & rd & ~is_empty;
        push_on_empty = wr & rd & is_empty;
        ov_now        = wr & ~rd & is_full;
        ud_now        = rd & is_empty;
        do_write      = (push_only | swap | push_on_empty) & ~rst;
        do_read       = (pop_only | swap) & ~rst;
        ptr_minus1    = pointer - ONE;
        raddr         = ptr_minus1[POINTER_WIDTH-1:0];
        waddr         = swap ? ptr_minus1[POINTER_WIDTH-1:0] : pointer[POINTER_WIDTH-1:0];
        ptr_next      = pointer;
        if (push_only | push_on_empty) begin
            ptr_next = pointer + ONE;
        end else if (pop_only) begin
            ptr_next = ptr_minus1;
        end
        state_next = lifo_state_for(ptr_next == '0, ptr_next == FULL_COUNT);
    end

    // FSM, occupancy counter, flags and error strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_EMPTY;
            pointer    <= '0;
            lifo_empty <= 1'b1;
            lifo_full  <= 1'b0;
            data_valid <= 1'b0;
            lifo_ov    <= 1'b0;
            lifo_ud    <= 1'b0;
        end else begin
            state      <= state_next;
            pointer    <= ptr_next;
            lifo_empty <= (state_next == S_EMPTY);
            lifo_full  <= (state_next == S_FULL);
            data_valid <= do_read;
`ifdef LIFO_STICKY_ERR_EN
            lifo_ov    <= lifo_ov | ov_now;
            lifo_ud    <= lifo_ud | ud_now;
`else
            lifo_ov    <= ov_now;
            lifo_ud    <= ud_now;
`endif
        end
    end

    lifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (POINTER_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (do_write),
        .waddr (waddr),
        .wdata (data_in),
        .re    (do_read),
        .raddr (raddr),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_lifo_stack_core.sv
// tb/tb_lifo_stack_core.sv - directed and randomized checks of lifo_stack_core against a queue model
module tb_lifo_stack_core;

    localparam int DW    = 16;
    localparam int PW    = 4;
    localparam int DEPTH = 1 << PW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          lifo_empty;
    logic          lifo_full;
    logic [PW:0]   pointer;
    logic          lifo_ov;
    logic          lifo_ud;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0] stack_q[$];
    logic [DW-1:0] exp_dout;
    logic          exp_dv;
    logic          exp_ov;
    logic          exp_ud;

    always #5 clk = ~clk;

    lifo_stack_core #(
        .DATA_WIDTH    (DW),
        .POINTER_WIDTH (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr),
        .rd         (rd),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .lifo_empty (lifo_empty),
        .lifo_full  (lifo_full),
        .pointer    (pointer),
        .lifo_ov    (lifo_ov),
        .lifo_ud    (lifo_ud)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour of one clock edge
    task automatic model_edge(input logic r, input logic w, input logic p, input logic [DW-1:0] d);
        logic ov_now;
        logic ud_now;
        int   n;
        if (r) begin
            stack_q.delete();
            exp_dout = '0;
            exp_dv   = 1'b0;
            exp_ov   = 1'b0;
            exp_ud   = 1'b0;
            return;
        end
        n      = stack_q.size();
        ov_now = w && !p && (n == DEPTH);
        ud_now = p && (n == 0);
        exp_dv = 1'b0;
        if (w && p) begin
            if (n > 0) begin
                exp_dout     = stack_q[n-1];
                stack_q[n-1] = d;
                exp_dv       = 1'b1;
            end else begin
                stack_q.push_back(d);
            end
        end else if (w) begin
            if (n < DEPTH) stack_q.push_back(d);
        end else if (p) begin
            if (n > 0) begin
                exp_dout = stack_q.pop_back();
                exp_dv   = 1'b1;
            end
        end
`ifdef LIFO_STICKY_ERR_EN
        exp_ov = exp_ov | ov_now;
        exp_ud = exp_ud | ud_now;
`else
        exp_ov = ov_now;
        exp_ud = ud_now;
`endif
    endtask

    task automatic step(input logic r, input logic w, input logic p, input logic [DW-1:0] d);
        @(negedge clk);
        rst     = r;
        wr      = w;
        rd      = p;
        data_in = d;
        @(posedge clk);
        model_edge(r, w, p, d);
        #1;
        check("pointer",    32'(pointer),    32'(stack_q.size()));
        check("lifo_empty", 32'(lifo_empty), 32'(stack_q.size() == 0));
        check("lifo_full",  32'(lifo_full),  32'(stack_q.size() == DEPTH));
        check("data_valid", 32'(data_valid), 32'(exp_dv));
        check("lifo_ov",    32'(lifo_ov),    32'(exp_ov));
        check("lifo_ud",    32'(lifo_ud),    32'(exp_ud));
        check("data_out",   32'(data_out),   32'(exp_dout));
    endtask

    initial begin
        int p_push;
        exp_dout = '0;
        exp_dv   = 1'b0;
        exp_ov   = 1'b0;
        exp_ud   = 1'b0;

        // Reset with both requests asserted
        step(1'b1, 1'b1, 1'b1, 16'hFFFF);
        step(1'b1, 1'b1, 1'b1, 16'hFFFF);
        // Fill, overflow, drain, underflow
        for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 1'b0, 16'(i));
        step(1'b0, 1'b1, 1'b0, 16'hBEEF);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 1'b1, 16'h0);
        // Swap on a single entry, then pop it
        step(1'b0, 1'b1, 1'b0, 16'h00AA);
        step(1'b0, 1'b1, 1'b1, 16'h00BB);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        // Push+pop while empty
        step(1'b0, 1'b1, 1'b1, 16'h1234);
        // Swap while full
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 1'b0, 16'(16'h0100 + i));
        step(1'b0, 1'b1, 1'b1, 16'h5A5A);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        // Reset mid-fill
        step(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'(16'h0200 + i));
        step(1'b1, 1'b1, 1'b0, 16'h7777);

        // Randomized phases biased toward filling or draining
        for (int ph = 0; ph < 40; ph++) begin
            case ($urandom_range(2, 0))
                0:       p_push = 20;
                1:       p_push = 50;
                default: p_push = 85;
            endcase
            for (int k = 0; k < 50; k++) begin
                step(($urandom_range(199, 0) == 0),
                     ($urandom_range(99, 0) < p_push),
                     ($urandom_range(99, 0) < (100 - p_push)),
                     16'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
